// File: rtl/gf16_dom_mul_pipe.sv
// Two-share DOM GF(2^4) multiplier, one register layer on the partial products.
// Operand B runs through a DELAY-deep share delay line so it lines up with A.
module gf16_dom_mul_pipe #(
  parameter int DELAY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [3:0] r,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic       out_valid
);

  if (DELAY < 0 || DELAY > 3) begin : g_bad_delay
    $error("gf16_dom_mul_pipe: DELAY must be 0..3");
  end

  // Polynomial basis, x^4 + x + 1.
  function automatic logic [3:0] gf_mul(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  logic [7:0] w_bd;
  logic [3:0] w_bd0;
  logic [3:0] w_bd1;

  if (DELAY <= 0) begin : g_nodly
    assign w_bd = {b1, b0};
  end else begin : g_dly
    logic [7:0] r_dly [DELAY];

    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int i = 0; i < DELAY; i++)
          r_dly[i] <= '0;
      end else begin
        r_dly[0] <= {b1, b0};
        for (int i = 1; i < DELAY; i++)
          r_dly[i] <= r_dly[i-1];
      end
    end

    assign w_bd = r_dly[DELAY-1];
  end

  assign w_bd0 = w_bd[3:0];
  assign w_bd1 = w_bd[7:4];

  // Cross-domain terms are refreshed with r before they are registered.
  logic [3:0] w_p00;
  logic [3:0] w_p01;
  logic [3:0] w_p10;
  logic [3:0] w_p11;

  assign w_p00 = gf_mul(a0, w_bd0);
  assign w_p11 = gf_mul(a1, w_bd1);
  assign w_p01 = gf_mul(a0, w_bd1) ^ r;
  assign w_p10 = gf_mul(a1, w_bd0) ^ r;

  logic [3:0] r_p00;
  logic [3:0] r_p01;
  logic [3:0] r_p10;
  logic [3:0] r_p11;
  logic       r_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p00   <= '0;
      r_p01   <= '0;
      r_p10   <= '0;
      r_p11   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_p00 <= w_p00;
        r_p01 <= w_p01;
        r_p10 <= w_p10;
        r_p11 <= w_p11;
      end
    end
  end

  assign out0      = r_p00 ^ r_p01;
  assign out1      = r_p11 ^ r_p10;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_gf16_dom_mul_pipe.sv
// Directed bench for gf16_dom_mul_pipe: DELAY=1 vector table and
// stream, DELAY=2 mid-stream reset.
module tb_gf16_dom_mul_pipe;

  logic       CLK;
  logic       rst1, iv1, ov1;
  logic [3:0] a0_1, a1_1, b0_1, b1_1, r_1, o0_1, o1_1;
  logic       rst2, iv2, ov2;
  logic [3:0] a0_2, a1_2, b0_2, b1_2, r_2, o0_2, o1_2;

  int checks   = 0;
  int failures = 0;

  gf16_dom_mul_pipe #(.DELAY(1)) u_d1 (
    .CLK(CLK), .RST(rst1), .in_valid(iv1),
    .a0(a0_1), .a1(a1_1), .b0(b0_1), .b1(b1_1), .r(r_1),
    .out0(o0_1), .out1(o1_1), .out_valid(ov1)
  );

  gf16_dom_mul_pipe #(.DELAY(2)) u_d2 (
    .CLK(CLK), .RST(rst2), .in_valid(iv2),
    .a0(a0_2), .a1(a1_2), .b0(b0_2), .b1(b1_2), .r(r_2),
    .out0(o0_2), .out1(o1_2), .out_valid(ov2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] a0, a1, b0, b1, r, p;
  } vec_t;

  // Reference: carry-less product then reduction by x^4+x+1.
  function automatic logic [3:0] gm(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] t;
    t = '0;
    for (int i = 0; i < 4; i++)
      if (y[i]) t = t ^ ({3'b000, x} << i);
    for (int i = 6; i >= 4; i--)
      if (t[i]) t = t ^ (7'b0010011 << (i - 4));
    return t[3:0];
  endfunction

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  vec_t tab [11];
  logic [3:0] sa0 [17], sa1 [17], sb0 [17], sb1 [17], sr [17];
  logic [3:0] h0, h1, m2, m3;

  initial begin
    tab[0]  = '{4'h7, 4'h5, 4'hC, 4'h4, 4'h9, 4'h3};
    tab[1]  = '{4'h3, 4'hC, 4'hA, 4'h5, 4'h0, 4'hA};
    tab[2]  = '{4'h3, 4'hC, 4'hA, 4'h5, 4'hF, 4'hA};
    tab[3]  = '{4'h4, 4'h5, 4'h2, 4'h5, 4'h6, 4'h7};
    tab[4]  = '{4'hB, 4'hB, 4'h1, 4'h8, 4'h3, 4'h0};
    tab[5]  = '{4'h0, 4'h2, 4'hE, 4'hC, 4'hA, 4'h4};
    tab[6]  = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h5, 4'h5};
    tab[7]  = '{4'hD, 4'h9, 4'h6, 4'h2, 4'h8, 4'h3};
    tab[8]  = '{4'h8, 4'h0, 4'hF, 4'h7, 4'h1, 4'hC};
    tab[9]  = '{4'h5, 4'hC, 4'h2, 4'h0, 4'hE, 4'h1};
    tab[10] = '{4'hA, 4'hC, 4'h1, 4'h6, 4'h2, 4'h1};

    rst1 = 1'b1; iv1 = 1'b1;
    rst2 = 1'b1; iv2 = 1'b1;
    a0_1 = '0; a1_1 = '0; b0_1 = '0; b1_1 = '0; r_1 = '0;
    a0_2 = '0; a1_2 = '0; b0_2 = '0; b1_2 = '0; r_2 = '0;

    // Reset with live, random inputs.
    for (int c = 0; c < 2; c++) begin
      a0_1 = 4'($urandom); a1_1 = 4'($urandom);
      b0_1 = 4'($urandom); b1_1 = 4'($urandom); r_1 = 4'($urandom);
      a0_2 = 4'($urandom); a1_2 = 4'($urandom);
      b0_2 = 4'($urandom); b1_2 = 4'($urandom); r_2 = 4'($urandom);
      step();
      chk("rst_out0", o0_1, 4'h0);
      chk("rst_out1", o1_1, 4'h0);
      chk("rst_valid", {3'b0, ov1}, 4'h0);
      chk("rst_valid_d2", {3'b0, ov2}, 4'h0);
    end
    rst1 = 1'b0; iv1 = 1'b0;
    rst2 = 1'b0; iv2 = 1'b0;
    step();
    chk("post_rst_valid", {3'b0, ov1}, 4'h0);
    chk("post_rst_out0", o0_1, 4'h0);

    // Table: B one cycle ahead of A.
    for (int k = 0; k < 11; k++) begin
      iv1 = 1'b0;
      b0_1 = tab[k].b0; b1_1 = tab[k].b1;
      step();
      iv1 = 1'b1;
      a0_1 = tab[k].a0; a1_1 = tab[k].a1; r_1 = tab[k].r;
      b0_1 = 4'($urandom); b1_1 = 4'($urandom);
      step();
      chk($sformatf("vec%0d_valid", k), {3'b0, ov1}, 4'h1);
      chk($sformatf("vec%0d_prod", k), o0_1 ^ o1_1, tab[k].p);
      if (k == 1) m2 = o0_1;
      if (k == 2) m3 = o0_1;
    end
    checks++;
    if (m2 === m3) begin
      failures++;
      $display("FAIL mask_share0 actual=%h required!=%h", m3, m2);
    end

    // Hold through a 3-cycle gap with toggling inputs.
    iv1 = 1'b0;
    h0 = o0_1; h1 = o1_1;
    for (int c = 0; c < 3; c++) begin
      a0_1 = ~a0_1; a1_1 = a1_1 ^ 4'h5; r_1 = ~r_1;
      step();
      chk("gap_valid", {3'b0, ov1}, 4'h0);
      chk("gap_out0", o0_1, h0);
      chk("gap_out1", o1_1, h1);
    end

    // 16 back-to-back products.
    for (int i = 0; i < 17; i++) begin
      sa0[i] = 4'($urandom); sa1[i] = 4'($urandom);
      sb0[i] = 4'($urandom); sb1[i] = 4'($urandom);
      sr[i]  = 4'($urandom);
    end
    iv1 = 1'b0;
    b0_1 = sb0[0]; b1_1 = sb1[0];
    step();
    for (int i = 0; i < 16; i++) begin
      iv1 = 1'b1;
      a0_1 = sa0[i]; a1_1 = sa1[i]; r_1 = sr[i];
      b0_1 = sb0[i+1]; b1_1 = sb1[i+1];
      step();
      chk($sformatf("strm%0d_valid", i), {3'b0, ov1}, 4'h1);
      chk($sformatf("strm%0d_prod", i), o0_1 ^ o1_1,
          gm(sa0[i] ^ sa1[i], sb0[i] ^ sb1[i]));
    end
    iv1 = 1'b0;
    step();
    chk("strm_end_valid", {3'b0, ov1}, 4'h0);

    // DELAY=2: stream, reset mid-stream, then B=0 window.
    for (int i = 0; i < 6; i++) begin
      b0_2 = sb0[i]; b1_2 = sb1[i];
      iv2 = (i >= 2);
      if (i >= 2) begin
        a0_2 = sa0[i-2]; a1_2 = sa1[i-2]; r_2 = sr[i-2];
      end
      step();
      if (i >= 2)
        chk($sformatf("d2_%0d_prod", i), o0_2 ^ o1_2,
            gm(sa0[i-2] ^ sa1[i-2], sb0[i-2] ^ sb1[i-2]));
    end
    rst2 = 1'b1; iv2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("d2_rst_valid", {3'b0, ov2}, 4'h0);
    chk("d2_rst_out0", o0_2, 4'h0);
    chk("d2_rst_out1", o1_2, 4'h0);
    for (int c = 0; c < 4; c++) begin
      iv2 = 1'b1;
      b0_2 = sb0[8+c]; b1_2 = sb1[8+c];
      a0_2 = sa0[8+c]; a1_2 = sa1[8+c];
      r_2 = (c < 2) ? 4'(4'h6 + c) : sr[8+c];
      step();
      chk($sformatf("d2_post%0d_valid", c), {3'b0, ov2}, 4'h1);
      if (c < 2) begin
        chk($sformatf("d2_post%0d_prod", c), o0_2 ^ o1_2, 4'h0);
        chk($sformatf("d2_post%0d_out0", c), o0_2, 4'(4'h6 + c));
      end else begin
        chk($sformatf("d2_post%0d_prod", c), o0_2 ^ o1_2,
            gm(sa0[8+c] ^ sa1[8+c], sb0[6+c] ^ sb1[6+c]));
      end
    end
    iv2 = 1'b0;
    step();
    chk("d2_end_valid", {3'b0, ov2}, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
